// File: rtl/dp_sequencer_pkg.sv
// Shared constants for the dp_sequencer slice: opcodes, ALU ops, FSM states
// and instruction field positions.
package dp_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_LDI = 3'b100,
        OP_MOV = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    localparam int OPC_W   = 3;
    localparam int INSTR_W = 12;
    localparam int OPC_LSB = 9;
    localparam int RD_LSB  = 6;
    localparam int RS1_LSB = 3;
    localparam int RS2_LSB = 0;

endpackage

// File: rtl/dp_sequencer_if.sv
// Instruction handshake plus register-file / ALU bus seen by dp_sequencer.
interface dp_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [11:0]   instr;
    logic [DW-1:0] instr_imm;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rf_d_out_a;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_o;
    logic          alu_cout;
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;
    logic          err;
    logic          carry;
    logic [DW-1:0] retired;

    modport master (
        input  instr_valid, instr, instr_imm, rf_d_out_a, alu_o, alu_cout,
        output instr_ready, rd_addr_a, rd_addr_b, alu_op, wr, wr_addr, wr_data,
               done, err, carry, retired
    );

    modport slave (
        output instr_valid, instr, instr_imm, rf_d_out_a, alu_o, alu_cout,
        input  instr_ready, rd_addr_a, rd_addr_b, alu_op, wr, wr_addr, wr_data,
               done, err, carry, retired
    );
endinterface

// File: rtl/dp_sequencer_decode.sv
// Combinational opcode decoder for dp_sequencer.
module dp_decode
    import dp_sequencer_pkg::*;
(
    input  logic [2:0] opcode,
    output alu_op_e    alu_op,
    output logic       is_ldi,
    output logic       is_mov,
    output logic       is_arith,
    output logic       illegal
);
    always_comb begin
        alu_op   = ALU_ADD;
        is_ldi   = 1'b0;
        is_mov   = 1'b0;
        is_arith = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD: begin alu_op = ALU_ADD; is_arith = 1'b1; end
            OP_SUB: begin alu_op = ALU_SUB; is_arith = 1'b1; end
            OP_AND: alu_op = ALU_AND;
            OP_OR:  alu_op = ALU_OR;
            OP_LDI: is_ldi = 1'b1;
            // MOV reuses OR with both read ports on rs1
            OP_MOV: begin alu_op = ALU_OR; is_mov = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/dp_sequencer.sv
// Three-state (IDLE/EXEC/WB) sequencer driving an external ALU and register file.
module dp_sequencer
    import dp_sequencer_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    dp_sequencer_if.master bus
);
    state_e          state_q, state_d;
    logic [2:0]      opcode_q;
    logic [AW-1:0]   rd_q, rs1_q, rs2_q;
    logic [DW-1:0]   imm_q, res_q, retired_q;
    logic            carry_q;

    alu_op_e         dec_alu_op;
    logic            is_ldi, is_mov, is_arith, illegal;
    logic            accept;
    logic            unused_ok;

    dp_decode u_decode (
        .opcode   (opcode_q),
        .alu_op   (dec_alu_op),
        .is_ldi   (is_ldi),
        .is_mov   (is_mov),
        .is_arith (is_arith),
        .illegal  (illegal)
    );

    assign accept = bus.instr_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.instr_valid) state_d = EXEC;
            EXEC:    state_d = illegal ? IDLE : WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= bus.instr[OPC_LSB +: OPC_W];
                rd_q     <= bus.instr[RD_LSB  +: AW];
                rs1_q    <= bus.instr[RS1_LSB +: AW];
                rs2_q    <= bus.instr[RS2_LSB +: AW];
                imm_q    <= bus.instr_imm;
            end
            if (state_q == EXEC && !illegal) begin
                res_q <= is_ldi ? imm_q : bus.alu_o;
                if (is_arith) carry_q <= bus.alu_cout;
            end
            if (state_q == WB) retired_q <= retired_q + DW'(1);
        end
    end

    // Control outputs decode straight from state so reset drops them immediately
    assign bus.instr_ready = (state_q == IDLE);
    assign bus.rd_addr_a   = rs1_q;
    assign bus.rd_addr_b   = (state_q == EXEC && is_mov) ? rs1_q : rs2_q;
    assign bus.alu_op      = dec_alu_op;
    assign bus.wr          = (state_q == WB);
    assign bus.done        = (state_q == WB);
    assign bus.err         = (state_q == EXEC) && illegal;
    assign bus.wr_addr     = rd_q;
    assign bus.wr_data     = res_q;
    assign bus.carry       = carry_q;
    assign bus.retired     = retired_q;

    // Register-file readback is only for the debug hook
    assign unused_ok = ^bus.rf_d_out_a;
endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench: dp_sequencer with behavioural ALU and register file.
module tb_dp_sequencer;
    import dp_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;

    dp_sequencer_if #(.DW(16), .AW(3)) bus ();

    dp_sequencer #(.DW(16), .AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Environment: register file and ALU that the sequencer drives
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] op_a, op_b;
    logic [16:0] wide;

    always @(posedge clk) if (bus.wr) rf[bus.wr_addr] <= bus.wr_data;

    assign bus.rf_d_out_a = rf[bus.rd_addr_a];

    always_comb begin
        op_a = rf[bus.rd_addr_a];
        op_b = rf[bus.rd_addr_b];
        wide = '0;
        case (bus.alu_op)
            2'b00: wide = {1'b0, op_a} + {1'b0, op_b};
            2'b01: wide = {(op_a >= op_b), op_a - op_b};
            2'b10: wide = {1'b0, op_a & op_b};
            default: wide = {1'b0, op_a | op_b};
        endcase
        bus.alu_o    = wide[15:0];
        bus.alu_cout = wide[16];
    end

    // Reference architectural state
    logic [15:0] exp_rf [8] = '{default: 16'h0000};
    logic        exp_carry   = 1'b0;
    logic [15:0] exp_retired = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction; expects to be called at posedge+#1 while IDLE
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm, input bit noisy);
        logic        legal;
        logic [15:0] a, b, res;
        logic [16:0] sum;
        logic        c_new;
        logic [1:0]  aop;
        legal = (op <= 3'd5);
        a     = exp_rf[rs1];
        b     = (op == 3'd5) ? exp_rf[rs1] : exp_rf[rs2];
        sum   = {1'b0, a} + {1'b0, b};
        c_new = exp_carry;
        res   = 16'h0000;
        aop   = 2'b00;
        case (op)
            3'd0: begin res = sum[15:0]; c_new = sum[16]; aop = 2'b00; end
            3'd1: begin res = a - b;     c_new = (a >= b); aop = 2'b01; end
            3'd2: begin res = a & b;     aop = 2'b10; end
            3'd3: begin res = a | b;     aop = 2'b11; end
            3'd4: res = imm;
            3'd5: begin res = a;         aop = 2'b11; end
            default: ;
        endcase

        check("ready_idle", bus.instr_ready, 1);
        bus.instr       = {op, rd, rs1, rs2};
        bus.instr_imm   = imm;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.instr       = 12'($urandom);
        bus.instr_imm   = 16'($urandom);
        check("exec_ready", bus.instr_ready, 0);
        check("exec_err", bus.err, !legal);
        check("exec_done", bus.done, 0);
        check("exec_wr", bus.wr, 0);
        if (legal && op != 3'd4) begin
            check("exec_rd_a", bus.rd_addr_a, rs1);
            check("exec_rd_b", bus.rd_addr_b, (op == 3'd5) ? rs1 : rs2);
            check("exec_alu_op", bus.alu_op, aop);
        end
        @(posedge clk); #1;
        if (legal) begin
            check("wb_ready", bus.instr_ready, 0);
            check("wb_done", bus.done, 1);
            check("wb_wr", bus.wr, 1);
            check("wb_addr", bus.wr_addr, rd);
            check("wb_data", bus.wr_data, res);
            @(posedge clk); #1;
            exp_rf[rd]  = res;
            exp_carry   = c_new;
            exp_retired = exp_retired + 16'd1;
        end
        bus.instr_valid = 1'b0;
        check("post_ready", bus.instr_ready, 1);
        check("post_done", bus.done, 0);
        check("post_wr", bus.wr, 0);
        check("post_err", bus.err, 0);
        check("rf_rd", rf[rd], exp_rf[rd]);
        check("carry", bus.carry, exp_carry);
        check("retired", bus.retired, exp_retired);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic [15:0] exp_val;
        logic        exp_c;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd4, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 16'd1};
        vecs[1] = '{3'd4, 3'd2, 3'd0, 3'd0, 16'h0F0F, 16'h0F0F, 1'b0, 16'd2};
        vecs[2] = '{3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h2143, 1'b0, 16'd3};
        vecs[3] = '{3'd4, 3'd4, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 16'd4};
        vecs[4] = '{3'd0, 3'd5, 3'd4, 3'd4, 16'h0000, 16'hFFFE, 1'b1, 16'd5};
        vecs[5] = '{3'd2, 3'd6, 3'd1, 3'd2, 16'h0000, 16'h0204, 1'b1, 16'd6};
        vecs[6] = '{3'd1, 3'd7, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b1, 16'd7};
        vecs[7] = '{3'd3, 3'd6, 3'd1, 3'd2, 16'h0000, 16'h1F3F, 1'b1, 16'd8};
        vecs[8] = '{3'd5, 3'd0, 3'd1, 3'd7, 16'h0000, 16'h1234, 1'b1, 16'd9};
        vecs[9] = '{3'd6, 3'd3, 3'd1, 3'd2, 16'hBEEF, 16'h2143, 1'b1, 16'd9};

        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.instr_imm   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.instr_ready, 1);
        check("rst_wr", bus.wr, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_addrs", {bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr}, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_alu_op", bus.alu_op, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0);
            check("tbl_val", rf[vecs[i].rd], vecs[i].exp_val);
            check("tbl_carry", bus.carry, vecs[i].exp_c);
            check("tbl_retired", bus.retired, vecs[i].exp_ret);
        end

        // Reset during write-back of ADD r3,r1,r1 must abort the write
        bus.instr       = {3'd0, 3'd3, 3'd1, 3'd1};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_wb", bus.wr, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_wr", bus.wr, 0);
        check("abort_done", bus.done, 0);
        check("abort_ready", bus.instr_ready, 1);
        check("abort_carry", bus.carry, 0);
        check("abort_retired", bus.retired, 0);
        check("abort_addrs", {bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr}, 0);
        check("abort_wr_data", bus.wr_data, 0);
        check("abort_alu_op", bus.alu_op, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_r3", rf[3], 16'h2143);
        exp_carry   = 1'b0;
        exp_retired = 16'h0000;
        @(posedge clk); #1;
        issue(3'd4, 3'd2, 3'd0, 3'd0, 16'h5555, 1'b0);
        check("after_abort_r2", rf[2], 16'h5555);
        check("after_abort_ret", bus.retired, 16'd1);

        // Back-to-back read-after-write
        issue(3'd4, 3'd1, 3'd0, 3'd0, 16'h0001, 1'b0);
        for (int i = 0; i < 3; i++) issue(3'd0, 3'd1, 3'd1, 3'd1, 16'h0000, 1'b0);
        check("raw_r1", rf[1], 16'h0008);

        // Retire counter wrap
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        exp_retired = 16'hFFFF;
        issue(3'd4, 3'd4, 3'd0, 3'd0, 16'hABCD, 1'b0);
        check("wrap_retired", bus.retired, 16'h0000);

        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                  16'($urandom), 1'b1);
        end
        for (int r = 0; r < 8; r++) check("final_rf", rf[r], exp_rf[r]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle instruction sequencer for the 16-bit ALU and the 8x16 register file.
- Accepts one register-register or load-immediate instruction at a time through a valid/ready handshake.
- For each instruction it drives the register-file read addresses and the ALU op, captures the ALU result, then writes it back to the register file.
- Sits between an instruction source (test bench or future fetch unit) and the `alu` / `reg_file` pair, which stay external.

Parameters:
- DW, 16, datapath width: ALU operands, immediate, write data, retire counter.
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  12  [11:9] opcode, [8:6] rd, [5:3] rs1, [2:0] rs2.
- instr_imm  in  DW  immediate; used by LDI only.
- rd_addr_a  out  AW  to reg_file port A.
- rd_addr_b  out  AW  to reg_file port B.
- rf_d_out_a  in  DW  from reg_file port A.
- alu_op  out  2  to alu: 00 add, 01 sub, 10 and, 11 or.
- alu_o  in  DW  ALU result.
- alu_cout  in  1  ALU carry out.
- wr  out  1  reg_file write enable.
- wr_addr  out  AW  reg_file write address.
- wr_data  out  DW  reg_file write data.
- done  out  1  one-cycle pulse in the write-back cycle.
- err  out  1  one-cycle pulse for an illegal opcode.
- carry  out  1  carry flag (sticky until the next ADD/SUB).
- retired  out  DW  count of completed legal instructions.

Behaviour:
- Opcodes:
  - 000 ADD: alu_op 00.
  - 001 SUB: alu_op 01.
  - 010 AND: alu_op 10.
  - 011 OR: alu_op 11.
  - 100 LDI: rd <= instr_imm.
  - 101 MOV: alu_op 11 with rd_addr_b = rs1, so result = rs1 | rs1.
  - 110, 111: illegal.
- FSM states and transitions:
  - IDLE -> EXEC on instr_valid & instr_ready. At that edge, opcode, rd, rs1, rs2 and imm are latched into internal registers.
  - EXEC -> WB. rd_addr_a = rs1_q; rd_addr_b = rs2_q (rs1_q for MOV); alu_op decoded from opcode_q.
    - At the EXEC->WB edge, res_q <= alu_o (or imm_q for LDI).
    - carry <= alu_cout for ADD/SUB only; other opcodes leave carry unchanged.
  - WB -> IDLE. wr=1, wr_addr=rd_q, wr_data=res_q, done=1; the reg_file commits at the WB->IDLE edge.
    - retired increments at that edge and wraps from 0xFFFF to 0.
  - Illegal opcode: IDLE -> EXEC -> IDLE.
    - err=1 during EXEC.
    - No WB state, no write, no done, carry unchanged, retired unchanged.
- Latency and throughput: accept edge to write-commit edge is 2 cycles; one instruction per 3 cycles; the next instruction can be accepted in the cycle after WB.
- instr_valid while not ready is ignored. The instruction source must hold instr_valid and instr stable until the handshake.
- Output values outside their active states:
  - wr, done and err are 0.
  - rd_addr_a/b hold the latched rs1_q/rs2_q.
  - alu_op holds its last decoded value.
  - wr_addr = rd_q; wr_data = res_q.
- Writes to r0 are legal; r0 is an ordinary register.
- Read-after-write: an instruction that reads the rd of the previous instruction sees the new value, because the write commits before the next EXEC.
- Reset:
  - Values: state=IDLE, instr_ready=1, wr=0, done=0, err=0, carry=0, retired=0, all latched fields 0, so rd_addr_a/b=0, wr_addr=0, wr_data=0, alu_op=00.
  - Reset in EXEC or WB aborts the instruction: no write is issued and wr drops asynchronously.
- rf_d_out_a is unused by the control logic. It is exposed only for the debug/readback bench hook.

Decomposition:
- Shared package holds:
  - Opcode constants OP_ADD..OP_MOV.
  - ALU op constants ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11.
  - FSM state encodings IDLE/EXEC/WB.
  - Instruction field bit positions.
- One natural sub-module, dp_decode: combinational opcode -> {alu_op, is_ldi, is_mov, is_arith, illegal}.
- The FSM, latches, carry and counter stay in dp_sequencer.

Test Plan:
- Bench instantiates dp_sequencer + alu + reg_file. All registers are 0 after reset.
- LDI r1,0x1234; LDI r2,0x0F0F -> r1=0x1234, r2=0x0F0F; done pulses 2 cycles after each accept; retired=2; instr_ready low for exactly 2 cycles per instruction.
- ADD r3,r1,r2 -> r3=0x2143, carry=0. Then LDI r4,0xFFFF; ADD r5,r4,r4 -> r5=0xFFFE, carry=1. Then AND r6,r1,r2 -> r6=0x0204, carry stays 1.
- SUB r7,r1,r1 -> r7=0x0000, carry=1 (no borrow). OR r6,r1,r2 -> 0x1F3F. MOV r0,r1 -> r0=0x1234.
- Illegal opcode 110 -> err pulses one cycle; no wr; retired and carry unchanged; instr_ready returns after 2 cycles.
- Assert reset during WB of ADD r3,r1,r1 -> wr drops immediately; r3 is not updated by the sequencer; all outputs are at reset values; the next LDI executes normally.
- Back-to-back dependency ADD r1,r1,r1 issued 3 times with r1=0x0001 -> r1=0x0008. Separately, preload retired=0xFFFF via 65535 LDIs (or force) -> one more instruction gives retired=0x0000.
